data_table_wr_arbiter: RTL and testbench

//  Owns the single write port (port B) of the hash-table data RAM and

---
 rtl/data_table_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_data_table_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_table_wr_arbiter.sv
// rtl/data_table_wr_arbiter.sv - data RAM port-B write arbiter: RAM clear > insert/delete round-robin
// Optional grant statistics counters: define DATA_TABLE_WR_ARB_STATS_EN.
module data_table_wr_arbiter #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_ram_run_i,
  output logic               clear_ram_done_o,
  input  logic               ins_req_i,
  input  logic [A_WIDTH-1:0] ins_addr_i,
  input  logic [D_WIDTH-1:0] ins_data_i,
  output logic               ins_gnt_o,
  input  logic               del_req_i,
  input  logic [A_WIDTH-1:0] del_addr_i,
  input  logic [D_WIDTH-1:0] del_data_i,
  output logic               del_gnt_o,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output logic [D_WIDTH-1:0] wr_data_o,
  output logic               wr_en_o,
  output logic               busy_o,
  output logic [31:0]        ins_wr_cnt_o,
  output logic [31:0]        del_wr_cnt_o
);

  typedef enum logic {SERVE, CLEAR} state_t;
  typedef enum logic {RR_INS, RR_DEL} rr_t;

  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  state_t             state;
  rr_t                rr_last;
  logic [A_WIDTH-1:0] clear_cnt;
  logic               grant_en;
  logic               tie;

  // A run pulse blocks grants in its own cycle so no write can race the clear.
  always_comb begin
    grant_en  = (state == SERVE) && !clear_ram_run_i;
    tie       = ins_req_i && del_req_i;
    ins_gnt_o = 1'b0;
    del_gnt_o = 1'b0;
    if (grant_en) begin
      if (tie) begin
        ins_gnt_o = (rr_last == RR_DEL);
        del_gnt_o = (rr_last == RR_INS);
      end else begin
        ins_gnt_o = ins_req_i;
        del_gnt_o = del_req_i;
      end
    end
  end

  assign busy_o = (state == CLEAR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= SERVE;
      rr_last          <= RR_DEL;
      clear_cnt        <= '0;
      wr_en_o          <= 1'b0;
      wr_addr_o        <= '0;
      wr_data_o        <= '0;
      clear_ram_done_o <= 1'b0;
    end else begin
      clear_ram_done_o <= 1'b0;
      case (state)
        SERVE: begin
          if (clear_ram_run_i) begin
            state     <= CLEAR;
            clear_cnt <= '0;
            wr_en_o   <= 1'b0;
          end else if (ins_gnt_o) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= ins_addr_i;
            wr_data_o <= ins_data_i;
          end else if (del_gnt_o) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= del_addr_i;
            wr_data_o <= del_data_i;
          end else begin
            wr_en_o   <= 1'b0;
          end
          if (grant_en && tie) begin
            rr_last <= ins_gnt_o ? RR_INS : RR_DEL;
          end
        end
        CLEAR: begin
          wr_en_o   <= 1'b1;
          wr_addr_o <= clear_cnt;
          wr_data_o <= '0;
          // A restart zeroes the sweep and suppresses the done of the aborted pass.
          if (clear_ram_run_i) begin
            clear_cnt <= '0;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
            if (clear_cnt == LAST_ADDR) begin
              state            <= SERVE;
              clear_ram_done_o <= 1'b1;
            end
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

`ifdef DATA_TABLE_WR_ARB_STATS_EN
  logic [31:0] ins_cnt;
  logic [31:0] del_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ins_cnt <= '0;
      del_cnt <= '0;
    end else if (clear_ram_run_i) begin
      ins_cnt <= '0;
      del_cnt <= '0;
    end else begin
      if (ins_gnt_o && (ins_cnt != 32'hFFFF_FFFF)) ins_cnt <= ins_cnt + 32'd1;
      if (del_gnt_o && (del_cnt != 32'hFFFF_FFFF)) del_cnt <= del_cnt + 32'd1;
    end
  end

  assign ins_wr_cnt_o = ins_cnt;
  assign del_wr_cnt_o = del_cnt;
`else
  assign ins_wr_cnt_o = 32'd0;
  assign del_wr_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_data_table_wr_arbiter.sv
// tb/tb_data_table_wr_arbiter.sv - self-checking bench for data_table_wr_arbiter (A_WIDTH=4, D_WIDTH=16)
module tb_data_table_wr_arbiter;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NV = 12;

`ifdef DATA_TABLE_WR_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_ram_run_i = 1'b0;
  logic          clear_ram_done_o;
  logic          ins_req_i = 1'b0;
  logic [AW-1:0] ins_addr_i = '0;
  logic [DW-1:0] ins_data_i = '0;
  logic          ins_gnt_o;
  logic          del_req_i = 1'b0;
  logic [AW-1:0] del_addr_i = '0;
  logic [DW-1:0] del_data_i = '0;
  logic          del_gnt_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_en_o;
  logic          busy_o;
  logic [31:0]   ins_wr_cnt_o;
  logic [31:0]   del_wr_cnt_o;

  data_table_wr_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .clear_ram_run_i(clear_ram_run_i), .clear_ram_done_o(clear_ram_done_o),
    .ins_req_i(ins_req_i), .ins_addr_i(ins_addr_i), .ins_data_i(ins_data_i), .ins_gnt_o(ins_gnt_o),
    .del_req_i(del_req_i), .del_addr_i(del_addr_i), .del_data_i(del_data_i), .del_gnt_o(del_gnt_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o), .busy_o(busy_o),
    .ins_wr_cnt_o(ins_wr_cnt_o), .del_wr_cnt_o(del_wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          ins_req;
    logic [AW-1:0] ins_addr;
    logic [DW-1:0] ins_data;
    logic          del_req;
    logic [AW-1:0] del_addr;
    logic [DW-1:0] del_data;
    logic          exp_ins;
    logic          exp_del;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  vec_t vecs[NV];
  wr_t  exp_q[$];
  wr_t  mon_e;
  int   tests = 0;
  int   fails = 0;
  int   exp_ins_cnt = 0;
  int   exp_del_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn);
    wr_t e;
    e = {a, d, dn};
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int k = 0; k < 16; k++) push_wr(4'(k), 16'h0, k == 15);
  endtask

  task automatic setv(input int i, input logic ir, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                      input logic dr, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                      input logic ei, input logic ed);
    vecs[i] = '{ir, ia, id, dr, da, dd, ei, ed};
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_stats(input string name);
    check({name, "_ins_cnt"}, ins_wr_cnt_o, STATS ? 32'(exp_ins_cnt) : 32'd0);
    check({name, "_del_cnt"}, del_wr_cnt_o, STATS ? 32'(exp_del_cnt) : 32'd0);
  endtask

  // Scoreboard: every RAM write must match the oldest expected write.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (wr_en_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(wr_addr_o), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr_o), 32'(mon_e.addr));
          check("wr_data", 32'(wr_data_o), 32'(mon_e.data));
          check("wr_done", 32'(clear_ram_done_o), 32'(mon_e.done));
        end
      end else begin
        check("done_without_write", 32'(clear_ram_done_o), 32'd0);
      end
    end
  end

  initial begin
    setv(0,  1, 4'h3, 16'hABCD, 0, 4'h0, 16'h0000, 1, 0);
    setv(1,  0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 0);
    setv(2,  1, 4'h1, 16'h1111, 1, 4'h2, 16'h2222, 1, 0);
    setv(3,  1, 4'h1, 16'h1112, 1, 4'h2, 16'h2222, 0, 1);
    setv(4,  1, 4'h1, 16'h1112, 1, 4'h4, 16'h4444, 1, 0);
    setv(5,  1, 4'h6, 16'h1113, 1, 4'h4, 16'h4444, 0, 1);
    setv(6,  1, 4'h6, 16'h1113, 0, 4'h0, 16'h0000, 1, 0);
    setv(7,  0, 4'h0, 16'h0000, 1, 4'h5, 16'h5555, 0, 1);
    setv(8,  1, 4'h7, 16'h7777, 1, 4'h8, 16'h8888, 1, 0);
    setv(9,  0, 4'h0, 16'h0000, 1, 4'h8, 16'h8888, 0, 1);
    setv(10, 1, 4'h9, 16'h9999, 1, 4'hA, 16'hAAAA, 0, 1);
    setv(11, 1, 4'h9, 16'h9999, 0, 4'h0, 16'h0000, 1, 0);

    // Reset state
    tick();
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("rst_wr_data", 32'(wr_data_o), 32'd0);
    check("rst_done", 32'(clear_ram_done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check_stats("rst");
    rst_i = 1'b0;
    tick();

    // Full clear sweep
    clear_ram_run_i = 1'b1;
    push_clear();
    exp_ins_cnt = 0;
    exp_del_cnt = 0;
    @(negedge clk_i);
    check("clr_busy_run_cycle", 32'(busy_o), 32'd0);
    tick();
    clear_ram_run_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk_i);
      check($sformatf("clr_busy_c%0d", k), 32'(busy_o), (k <= 16) ? 32'd1 : 32'd0);
      tick();
    end

    // Table-driven arbitration vectors
    for (int i = 0; i < NV; i++) begin
      ins_req_i  = vecs[i].ins_req;
      ins_addr_i = vecs[i].ins_addr;
      ins_data_i = vecs[i].ins_data;
      del_req_i  = vecs[i].del_req;
      del_addr_i = vecs[i].del_addr;
      del_data_i = vecs[i].del_data;
      @(negedge clk_i);
      check($sformatf("v%0d_ins_gnt", i), 32'(ins_gnt_o), 32'(vecs[i].exp_ins));
      check($sformatf("v%0d_del_gnt", i), 32'(del_gnt_o), 32'(vecs[i].exp_del));
      check($sformatf("v%0d_one_hot", i), 32'(ins_gnt_o & del_gnt_o), 32'd0);
      if (vecs[i].exp_ins) begin
        push_wr(vecs[i].ins_addr, vecs[i].ins_data, 1'b0);
        exp_ins_cnt++;
      end
      if (vecs[i].exp_del) begin
        push_wr(vecs[i].del_addr, vecs[i].del_data, 1'b0);
        exp_del_cnt++;
      end
      tick();
    end
    ins_req_i = 1'b0;
    del_req_i = 1'b0;
    tick();
    @(negedge clk_i);
    check_stats("table");
    tick();

    // Requests pending across a clear; delete raised in the run cycle itself
    clear_ram_run_i = 1'b1;
    del_req_i  = 1'b1;
    del_addr_i = 4'h9;
    del_data_i = 16'hD00D;
    push_clear();
    exp_ins_cnt = 0;
    exp_del_cnt = 0;
    @(negedge clk_i);
    check("run_cycle_del_gnt", 32'(del_gnt_o), 32'd0);
    tick();
    clear_ram_run_i = 1'b0;
    @(negedge clk_i);
    check("clr_pend_del_gnt_c1", 32'(del_gnt_o), 32'd0);
    tick();
    ins_req_i  = 1'b1;
    ins_addr_i = 4'h5;
    ins_data_i = 16'hBEEF;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk_i);
      check($sformatf("clr_pend_gnt_c%0d", k), 32'(ins_gnt_o | del_gnt_o), 32'd0);
      if (k == 2) check_stats("run_zero");
      tick();
    end
    @(negedge clk_i);
    check("done_cycle_ins_gnt", 32'(ins_gnt_o), 32'd1);
    check("done_cycle_del_gnt", 32'(del_gnt_o), 32'd0);
    push_wr(4'h5, 16'hBEEF, 1'b0);
    exp_ins_cnt++;
    tick();
    ins_req_i = 1'b0;
    @(negedge clk_i);
    check("after_done_del_gnt", 32'(del_gnt_o), 32'd1);
    push_wr(4'h9, 16'hD00D, 1'b0);
    exp_del_cnt++;
    tick();
    del_req_i = 1'b0;
    tick();
    @(negedge clk_i);
    check_stats("pend");
    tick();

    // Restart pulse while the sweep is at address 7
    clear_ram_run_i = 1'b1;
    push_clear();
    exp_ins_cnt = 0;
    exp_del_cnt = 0;
    tick();
    clear_ram_run_i = 1'b0;
    repeat (7) tick();
    clear_ram_run_i = 1'b1;
    exp_q.delete();
    push_wr(4'h6, 16'h0, 1'b0);
    push_wr(4'h7, 16'h0, 1'b0);
    push_clear();
    @(negedge clk_i);
    check("restart_busy", 32'(busy_o), 32'd1);
    tick();
    clear_ram_run_i = 1'b0;
    repeat (20) tick();
    check("restart_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a clear
    clear_ram_run_i = 1'b1;
    push_clear();
    tick();
    clear_ram_run_i = 1'b0;
    repeat (4) tick();
    rst_i = 1'b1;
    exp_q.delete();
    exp_ins_cnt = 0;
    exp_del_cnt = 0;
    #1;
    check("midrst_wr_en", 32'(wr_en_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("midrst_done", 32'(clear_ram_done_o), 32'd0);
    tick();
    rst_i = 1'b0;
    repeat (20) tick();
    check("midrst_busy_after", 32'(busy_o), 32'd0);
    check_stats("midrst");
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
